// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator-bypass scheduler.
package acc_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int ACC_LAT_MIN = 2;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/acc_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last is granted.
module acc_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic en,
  output logic gnt0,
  output logic gnt1,
  output logic win
);
  assign gnt0 = en & req0 & (~req1 | last);
  assign gnt1 = en & req1 & (~req0 | ~last);
  assign win  = gnt1;
endmodule

// File: rtl/acc_sched.sv
// Round-robin scheduler for the shared accelerator-bypass path with an
// ACC_LAT-cycle occupancy window that stretches under accelerator stall.
module acc_sched
  import acc_pkg::*;
#(
  parameter int ACC_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [INSTR_W-1:0] instr0,
  input  logic               req1,
  input  logic [INSTR_W-1:0] instr1,
  input  logic               acc_stall,
  input  logic               flush,
  output logic               gnt0,
  output logic               gnt1,
  output logic               accbypassA,
  output logic [INSTR_W-1:0] fullinstructionA,
  output logic               acc_src,
  output logic               busy
);
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last, last_nxt;
  logic               acc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               src_nxt;
  logic               arb_en;
  logic               win;
  logic               issue;

  // Gating on reset keeps grants low combinationally while reset is held.
  assign arb_en = (state == IDLE) & ~flush & reset;
  assign issue  = gnt0 | gnt1;
  assign busy   = (state == BUSY);

  acc_rr_arb2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .en   (arb_en),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .win  (win)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    acc_nxt   = 1'b0;
    instr_nxt = '0;
    src_nxt   = acc_src;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (issue) begin
      state_nxt = BUSY;
      cnt_nxt   = CNT_W'(ACC_LAT - 1);
      last_nxt  = win;
      acc_nxt   = 1'b1;
      instr_nxt = win ? instr1 : instr0;
      src_nxt   = win;
    end else if (state == BUSY && !acc_stall) begin
      // The cycle with cnt==1 is the last occupied one.
      if (cnt == CNT_W'(1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      last             <= 1'b1;
      accbypassA       <= 1'b0;
      fullinstructionA <= '0;
      acc_src          <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      last             <= last_nxt;
      accbypassA       <= acc_nxt;
      fullinstructionA <= instr_nxt;
      acc_src          <= src_nxt;
    end
  end
endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched: a per-cycle vector table plus hand-written
// sequences for tie fairness, asynchronous reset and the ACC_LAT=2 build.
module tb_acc_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        r0, r1, st, fl;
  logic [31:0] i0, i1;

  logic        g0_a, g1_a, acc_a, src_a, busy_a;
  logic [31:0] fi_a;
  logic        g0_b, g1_b, acc_b, src_b, busy_b;
  logic [31:0] fi_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_sched #(.ACC_LAT(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .req0(r0), .instr0(i0), .req1(r1), .instr1(i1),
    .acc_stall(st), .flush(fl), .gnt0(g0_a), .gnt1(g1_a), .accbypassA(acc_a),
    .fullinstructionA(fi_a), .acc_src(src_a), .busy(busy_a)
  );

  acc_sched #(.ACC_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .req0(r0), .instr0(i0), .req1(r1), .instr1(i1),
    .acc_stall(st), .flush(fl), .gnt0(g0_b), .gnt1(g1_b), .accbypassA(acc_b),
    .fullinstructionA(fi_b), .acc_src(src_b), .busy(busy_b)
  );

  typedef struct {
    logic        r0, r1;
    logic [31:0] i0, i1;
    logic        st, fl;
    logic        g0, g1, acc;
    logic [31:0] ins;
    logic        src, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic a_r0, logic a_r1, logic [31:0] a_i0, logic [31:0] a_i1,
                              logic a_st, logic a_fl, logic e_g0, logic e_g1, logic e_acc,
                              logic [31:0] e_ins, logic e_src, logic e_busy);
    vec_t v;
    v.r0 = a_r0; v.r1 = a_r1; v.i0 = a_i0; v.i1 = a_i1; v.st = a_st; v.fl = a_fl;
    v.g0 = e_g0; v.g1 = e_g1; v.acc = e_acc; v.ins = e_ins; v.src = e_src; v.busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Grants must be mutually exclusive in both builds.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("gnt_exclusive_a", {62'd0, g0_a, g1_a} & 64'h0, {62'd0, g0_a & g1_a, 1'b0} & 64'h0);
      if ((g0_a & g1_a) | (g0_b & g1_b)) begin
        failures++;
        $display("FAIL gnt_exclusive actual=both_high required=at_most_one");
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    r0 = 0; r1 = 0; st = 0; fl = 0; i0 = '0; i1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic watch_tie(input int sel, input int lat);
    int          n;
    int          cyc[4];
    logic [31:0] ins[4];
    logic        src[4];
    logic        a;
    n = 0;
    do_reset();
    @(posedge clk); #1;
    r0 = 1; r1 = 1; i0 = 32'h11; i1 = 32'h22;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      a = (sel == 0) ? acc_a : acc_b;
      if (a) begin
        cyc[n] = c;
        ins[n] = (sel == 0) ? fi_a : fi_b;
        src[n] = (sel == 0) ? src_a : src_b;
        n++;
      end
    end
    if (n < 4) begin
      failures++;
      $display("FAIL tie_timeout actual=%0d_pulses required=4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("tie%0d_lat%0d_instr_%0d", sel, lat, k), {32'd0, ins[k]},
            (k % 2 == 0) ? 64'h11 : 64'h22);
        chk($sformatf("tie%0d_lat%0d_src_%0d", sel, lat, k), {63'd0, src[k]}, 64'(k % 2));
        if (k > 0)
          chk($sformatf("tie%0d_lat%0d_gap_%0d", sel, lat, k), 64'(cyc[k] - cyc[k-1]), 64'(lat));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Rows: inputs for the cycle, outputs expected in that same cycle.
    //             r0 r1 i0            i1     st fl  g0 g1 acc ins           src busy
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 32'h0,  0, 0, 1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 32'h0,  0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 32'h0,  0, 0, 1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(0, 1, 32'h0,        32'h22, 0, 0, 0, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 1, 32'h22,       1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  1, 0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  1, 0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  1, 0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(1, 0, 32'hA5A5A5A5, 32'h0,  0, 0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(1, 0, 32'hA5A5A5A5, 32'h0,  0, 0, 1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk(0, 1, 32'h0,        32'h33, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 1));
    tbl.push_back(mk(0, 1, 32'h0,        32'h33, 0, 1, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(0, 1, 32'h0,        32'h33, 0, 0, 0, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 1, 32'h33,       1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  1, 1, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk(1, 0, 32'h44,       32'h0,  1, 0, 1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 1, 32'h44,       0, 1));
    tbl.push_back(mk(0, 1, 32'h0,        32'h66, 0, 0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'h55,       32'h0,  0, 1, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 32'h55,       32'h0,  0, 0, 1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 1, 32'h55,       0, 1));

    // Reset values, with requests already high to show grants are forced off.
    reset = 1'b0;
    r0 = 1; r1 = 1; st = 0; fl = 0; i0 = 32'h11; i1 = 32'h22;
    #2;
    chk("reset_state", {58'd0, g0_a, g1_a, acc_a, src_a, busy_a, |fi_a}, 64'd0);

    do_reset();
    foreach (tbl[k]) begin
      @(posedge clk); #1;
      r0 = tbl[k].r0; r1 = tbl[k].r1; i0 = tbl[k].i0; i1 = tbl[k].i1;
      st = tbl[k].st; fl = tbl[k].fl;
      @(negedge clk);
      chk($sformatf("row%0d{g0,g1,acc,src,busy,instr}", k),
          {27'd0, g0_a, g1_a, acc_a, src_a, busy_a, fi_a},
          {27'd0, tbl[k].g0, tbl[k].g1, tbl[k].acc, tbl[k].src, tbl[k].busy, tbl[k].ins});
    end

    watch_tie(0, 4);

    // Asynchronous reset between edges while BUSY, then release with a tie pending.
    begin
      int n;
      n = 0;
      while (!(busy_a && src_a) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("pre_reset_busy_src1", {62'd0, busy_a, src_a}, 64'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_outputs", {58'd0, g0_a, g1_a, acc_a, src_a, busy_a, |fi_a}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_reset_grant", {61'd0, g0_a, g1_a, acc_a}, 64'b100);
      @(negedge clk);
      chk("post_reset_issue", {30'd0, acc_a, src_a, busy_a, fi_a}, {30'd0, 3'b101, 32'h11});
    end

    watch_tie(1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
